// File: rtl/p_int_acc_sat.sv
// p_int_acc_sat: multi-lane saturating integer accumulator.
// Each accepted beat adds the exact sum of LANES operands to a running
// accumulator. The first beat of a vector seeds the accumulator with bias.
// Every step is clamped to the ACC_PREC range, and a sticky overflow flag
// records whether any clamp happened during the vector. The result is held
// in the OUT state until the consumer takes it.
module p_int_acc_sat #(
  parameter int LANES    = 4,
  parameter int IN_PREC  = 8,
  parameter int IN_SIGN  = 1,
  parameter int ACC_PREC = 16,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_PREC-1:0] in_data,
  input  logic                     in_last,
  input  logic [ACC_PREC-1:0]      bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_PREC-1:0]      out_data,
  output logic                     out_ovf,
  output logic [CNT_W-1:0]         out_beats
);

  // Wide enough that neither the lane sum nor the accumulate step can wrap.
  localparam int SUM_W = ACC_PREC + $clog2(LANES) + 2;
  localparam logic SIGNED_MODE = (IN_SIGN != 0);

  // Clamp limits, expressed in the wide working width.
  localparam logic [SUM_W-1:0] SAT_MAX = SIGNED_MODE ?
    {{(SUM_W-ACC_PREC+1){1'b0}}, {(ACC_PREC-1){1'b1}}} :
    {{(SUM_W-ACC_PREC){1'b0}}, {ACC_PREC{1'b1}}};
  localparam logic [SUM_W-1:0] SAT_MIN = SIGNED_MODE ?
    {{(SUM_W-ACC_PREC+1){1'b1}}, {(ACC_PREC-1){1'b0}}} :
    {SUM_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t               state;
  logic [ACC_PREC-1:0]  acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 beat_fire;
  logic                 first_beat;
  logic                 cnt_full;
  logic [IN_PREC-1:0]   lane;
  logic [SUM_W-1:0]     beat_sum;
  logic [ACC_PREC-1:0]  base_src;
  logic [SUM_W-1:0]     base_ext;
  logic [SUM_W-1:0]     exact;
  logic                 over;
  logic                 under;
  logic                 step_ovf;
  logic [ACC_PREC-1:0]  acc_next;

  assign beat_fire  = in_valid & in_ready;
  assign first_beat = (state == IDLE);
  assign cnt_full   = &cnt;

  // Exact sum of all lanes of the current beat, each sign- or zero-extended.
  always_comb begin
    lane     = '0;
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane     = in_data[i*IN_PREC +: IN_PREC];
      beat_sum = beat_sum + {{(SUM_W-IN_PREC){SIGNED_MODE & lane[IN_PREC-1]}}, lane};
    end
  end

  // Exact accumulate step (bias on the first beat, acc afterwards) and clamp.
  always_comb begin
    base_src = first_beat ? bias : acc;
    base_ext = {{(SUM_W-ACC_PREC){SIGNED_MODE & base_src[ACC_PREC-1]}}, base_src};
    exact    = base_ext + beat_sum;
    over     = 1'b0;
    under    = 1'b0;
    if (SIGNED_MODE) begin
      over  = ($signed(exact) > $signed(SAT_MAX));
      under = ($signed(exact) < $signed(SAT_MIN));
    end else begin
      over  = (exact > SAT_MAX);
    end
    step_ovf = over | under;
    if (over) begin
      acc_next = SAT_MAX[ACC_PREC-1:0];
    end else if (under) begin
      acc_next = SAT_MIN[ACC_PREC-1:0];
    end else begin
      acc_next = exact[ACC_PREC-1:0];
    end
  end

  // Vector FSM: seeds, accumulates, then holds the result until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_fire) begin
            acc <= acc_next;
            cnt <= CNT_W'(1);
            ovf <= step_ovf;
            if (in_last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (beat_fire) begin
            acc <= acc_next;
            cnt <= cnt_full ? cnt : cnt + 1'b1;
            ovf <= ovf | step_ovf | cnt_full;
            if (in_last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign out_beats = cnt;

endmodule

// File: tb/tb_p_int_acc_sat.sv
// Testbench for p_int_acc_sat: a signed instance checked through a
// scoreboard fed by an integer reference model, plus an unsigned instance.
module tb_p_int_acc_sat;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [15:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_beats;

  logic        u_in_valid;
  logic        u_in_ready;
  logic [31:0] u_in_data;
  logic        u_in_last;
  logic [15:0] u_bias;
  logic        u_out_valid;
  logic        u_out_ready;
  logic [15:0] u_out_data;
  logic        u_out_ovf;
  logic [7:0]  u_out_beats;

  typedef struct {
    int data;
    bit ovf;
    int beats;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_acc;
  bit   m_ovf;
  int   m_cnt;
  bit   m_open = 1'b0;

  always #5 clk = ~clk;

  p_int_acc_sat #(
    .LANES(4), .IN_PREC(8), .IN_SIGN(1), .ACC_PREC(16), .CNT_W(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_beats(out_beats)
  );

  p_int_acc_sat #(
    .LANES(4), .IN_PREC(8), .IN_SIGN(0), .ACC_PREC(16), .CNT_W(8)
  ) u_dut_u (
    .clk(clk), .reset(reset),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
    .in_last(u_in_last), .bias(u_bias),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
    .out_ovf(u_out_ovf), .out_beats(u_out_beats)
  );

  // Scoreboard: pop and compare every result the signed instance hands over.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_result got data=%0h with nothing expected", out_data);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (out_data !== 16'(e.data)) begin
          n_fail++;
          $display("[TB] FAIL result_data got=%0h expected=%0h", out_data, 16'(e.data));
        end
        n_checks++;
        if (out_ovf !== e.ovf) begin
          n_fail++;
          $display("[TB] FAIL result_ovf got=%0b expected=%0b", out_ovf, e.ovf);
        end
        n_checks++;
        if (out_beats !== 8'(e.beats)) begin
          n_fail++;
          $display("[TB] FAIL result_beats got=%0d expected=%0d", out_beats, e.beats);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Drive one beat into the signed instance, update the model, push at vector end.
  task automatic send_beat(input int l0, input int l1, input int l2, input int l3,
                           input bit last, input int b, output int waits);
    int s;
    bit acc_ok;
    bit done;
    if (!m_open) begin
      m_acc  = b;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_open = 1'b1;
    end
    s = m_acc + l0 + l1 + l2 + l3;
    if (s > 32767) begin
      s = 32767;
      m_ovf = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      m_ovf = 1'b1;
    end
    m_acc = s;
    if (m_cnt == 255) m_ovf = 1'b1;
    else m_cnt++;
    in_data  = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    in_last  = last;
    bias     = 16'(b);
    in_valid = 1'b1;
    waits    = 0;
    done     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      acc_ok = in_ready;
      @(posedge clk);
      #1;
      if (acc_ok) begin
        done = 1'b1;
        break;
      end
      waits++;
    end
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    bias     = 16'h5A5A;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL beat_accept got in_ready=%0b expected acceptance within 20 cycles", in_ready);
    end
    if (last) begin
      sb.push_back('{m_acc, m_ovf, m_cnt});
      m_open = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain got pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_data, out_ovf, out_beats} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values got rdy=%0b vld=%0b data=%0h ovf=%0b beats=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_data, out_ovf, out_beats);
    end
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int w;
    out_ready = 1'b1;
    send_beat(1, 2, 3, 4, 1'b1, 10, w);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_latency got out_valid=%0b expected 1", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_hold();
    int w;
    out_ready = 1'b0;
    send_beat(100, 100, 100, 100, 1'b0, 0, w);
    send_beat(100, 100, 100, 100, 1'b0, 0, w);
    send_beat(100, 100, 100, 100, 1'b1, 0, w);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({in_ready, out_valid, out_data, out_beats} !== {1'b0, 1'b1, 16'd1200, 8'd3}) begin
        n_fail++;
        $display("[TB] FAIL hold_stable cycle=%0d got rdy=%0b vld=%0b data=%0d beats=%0d expected 0 1 1200 3",
                 k, in_ready, out_valid, out_data, out_beats);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_release got in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic test_pos_sat();
    int w;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send_beat(1, 1, 1, 1, (k == 7), 32752, w);
    wait_drain();
    for (int k = 0; k < 8; k++) send_beat(1, 1, 1, 1, 1'b0, 32752, w);
    send_beat(-128, -128, -128, -128, 1'b1, 0, w);
    wait_drain();
  endtask

  task automatic test_neg_sat();
    int w;
    out_ready = 1'b1;
    send_beat(-1, 0, 0, 0, 1'b1, -32768, w);
    wait_drain();
    send_beat(1, 1, 1, 1, 1'b1, 0, w);
    wait_drain();
  endtask

  task automatic test_cnt_sat();
    int w;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) send_beat(1, 0, 0, 0, (k == 255), 5, w);
    wait_drain();
  endtask

  // Drive a single-beat vector into the unsigned instance.
  task automatic u_send(input logic [31:0] d, input logic [15:0] b);
    u_in_data  = d;
    u_bias     = b;
    u_in_last  = 1'b1;
    u_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (u_in_ready) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    u_in_valid = 1'b0;
  endtask

  task automatic test_unsigned();
    u_out_ready = 1'b1;
    u_send({8'd0, 8'd0, 8'd0, 8'd255}, 16'hFFFF);
    n_checks++;
    if ({u_out_valid, u_out_data, u_out_ovf, u_out_beats} !== {1'b1, 16'hFFFF, 1'b1, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL unsigned_sat got vld=%0b data=%0h ovf=%0b beats=%0d expected 1 ffff 1 1",
               u_out_valid, u_out_data, u_out_ovf, u_out_beats);
    end
    @(posedge clk);
    #1;
    u_send({8'd1, 8'd1, 8'd1, 8'd1}, 16'h0000);
    n_checks++;
    if ({u_out_valid, u_out_data, u_out_ovf, u_out_beats} !== {1'b1, 16'd4, 1'b0, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL unsigned_clear got vld=%0b data=%0h ovf=%0b beats=%0d expected 1 4 0 1",
               u_out_valid, u_out_data, u_out_ovf, u_out_beats);
    end
    @(posedge clk);
    #1;
    u_send({8'd255, 8'd255, 8'd255, 8'd255}, 16'h0000);
    n_checks++;
    if ({u_out_valid, u_out_data, u_out_ovf} !== {1'b1, 16'd1020, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL unsigned_zero_ext got vld=%0b data=%0d ovf=%0b expected 1 1020 0",
               u_out_valid, u_out_data, u_out_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b1;
    send_beat(5, 5, 5, 5, 1'b0, 7, w);
    send_beat(5, 5, 5, 5, 1'b0, 7, w);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_data, out_ovf, out_beats} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid got rdy=%0b vld=%0b data=%0h ovf=%0b beats=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_data, out_ovf, out_beats);
    end
    m_open = 1'b0;
    #3;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_no_output cycle=%0d got out_valid=%0b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w_a;
    int w_b;
    int w;
    out_ready = 1'b1;
    send_beat(1, 1, 1, 1, 1'b0, 1, w_a);
    send_beat(2, 2, 2, 2, 1'b1, 1, w);
    send_beat(-1, -1, -1, -1, 1'b1, -7, w_b);
    n_checks++;
    if (w_a !== 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_first_wait got=%0d expected 0", w_a);
    end
    n_checks++;
    if (w_b !== 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_bubble got=%0d expected 1", w_b);
    end
    wait_drain();
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    bias        = '0;
    out_ready   = 1'b0;
    u_in_valid  = 1'b0;
    u_in_data   = '0;
    u_in_last   = 1'b0;
    u_bias      = '0;
    u_out_ready = 1'b1;
    $display("[TB] starting p_int_acc_sat bench");
    test_reset();
    test_single();
    test_hold();
    test_pos_sat();
    test_neg_sat();
    test_cnt_sat();
    test_unsigned();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
